// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions for the instruction fetch path.
package instr_fetch_unit_pkg;

  localparam int unsigned DefaultAw = 8;
  localparam int unsigned DefaultDw = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Fetch output FIFO: circular buffer of {pc, instr, misalign} with a registered head.
// A flush empties it at the next edge and cancels any push or pop in that cycle.
module instr_fetch_unit_fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = DefaultAw,
  parameter int unsigned DW    = DefaultDw,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic [AW-1:0]   push_pc,
  input  logic [DW-1:0]   push_instr,
  input  logic            push_misalign,
  input  logic            pop_ready,
  output logic            head_valid,
  output logic [AW-1:0]   head_pc,
  output logic [DW-1:0]   head_instr,
  output logic            head_misalign,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = AW + DW + 1;

  logic [EntW-1:0] mem_q [DEPTH];
  logic [EntW-1:0] push_entry;
  logic [EntW-1:0] head_q, head_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign push_entry = {push_pc, push_instr, push_misalign};
  assign head_valid = (count_q != '0);
  assign do_push    = push & ~flush;
  assign do_pop     = head_valid & pop_ready & ~flush;

  assign count = count_q;
  assign {head_pc, head_instr, head_misalign} = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // The entry being written this edge becomes the head when it lands at the new read slot.
    head_d = mem_q[rd_ptr_d];
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_entry;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PCs, issues single outstanding memory reads and buffers
// {pc, instr} for decode. Misaligned PCs bypass memory and yield a flagged NOP.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = DefaultAw,
  parameter int unsigned DW    = DefaultDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_instr,
  output logic          if_misalign
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [AW-1:0]   held_pc_q, held_pc_d;
  logic            run_q;
  logic            req_seen_q;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   used;
  logic            busy, has_space, pc_aligned, accept;
  logic            push, push_misalign;
  logic [AW-1:0]   push_pc;
  logic [DW-1:0]   push_instr;

  // One slot is reserved for the request in flight so its response can always be pushed.
  assign busy       = (state_q != StIdle);
  assign used       = {1'b0, fifo_count} + {{CntW{1'b0}}, busy};
  assign has_space  = used < (CntW + 1)'(DEPTH);
  assign pc_aligned = (pc[1:0] == 2'b00);

  // run_q keeps pc_ready low while reset is held and for the first cycle after release.
  assign pc_ready = run_q & ~busy & has_space & ~flush;
  assign accept   = pc_valid & pc_ready;
  assign mem_req  = accept & pc_aligned;
  assign mem_addr = mem_req ? {pc[AW-1:2], 2'b00} : '0;

  always_comb begin
    state_d       = state_q;
    held_pc_d     = held_pc_q;
    push          = 1'b0;
    push_pc       = held_pc_q;
    push_instr    = mem_rdata;
    push_misalign = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (pc_aligned) begin
            state_d   = StWait;
            held_pc_d = pc;
          end else begin
            push          = 1'b1;
            push_pc       = pc;
            push_instr    = DW'(NopInstr);
            push_misalign = 1'b1;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StIdle;
          push    = ~flush;
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (mem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      held_pc_q  <= '0;
      run_q      <= 1'b0;
      req_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_pc_q  <= held_pc_d;
      run_q      <= 1'b1;
      req_seen_q <= req_seen_q | mem_req;
    end
  end

  instr_fetch_unit_fetch_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .push_pc      (push_pc),
    .push_instr   (push_instr),
    .push_misalign(push_misalign),
    .pop_ready    (if_ready),
    .head_valid   (if_valid),
    .head_pc      (if_pc),
    .head_instr   (if_instr),
    .head_misalign(if_misalign),
    .count        (fifo_count)
  );

  // A response with nothing outstanding is a memory protocol error; stale responses
  // between reset and the first request are tolerated.
  assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid && (state_q == StIdle) && req_seen_q));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter interface. Takes the current PC, fetches the 32-bit instruction word from instruction memory and hands {pc, instr} to decode.
- Sits between the PC register and decode. Hides variable memory latency with a request/response FSM and a small output FIFO.
- Supports flush on branch/jump redirect. In-flight responses are discarded after a flush.

Parameters:
- DEPTH, 2: output FIFO entries (power of 2, >=2).
- AW, 8: instruction address width, bytes.
- DW, 32: instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  AW  address to fetch, driven by the PC register.
- pc_valid  in  1  pc holds a fetch target.
- pc_ready  out  1  fetch accepted this cycle; the PC register advances on pc_valid&pc_ready.
- flush  in  1  redirect; drop all buffered and in-flight work.
- mem_req  out  1  memory read request, one-cycle pulse.
- mem_addr  out  AW  word-aligned read address {pc[AW-1:2],2'b00}.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DW  read data.
- if_valid  out  1  FIFO head valid to decode.
- if_ready  in  1  decode accepts head.
- if_pc  out  AW  pc of head entry.
- if_instr  out  DW  instruction of head entry.
- if_misalign  out  1  head pc[1:0]!=0; instruction forced to 32'h00000013 (NOP).

Behaviour:
- Reset: all outputs are 0, including pc_ready, mem_req, mem_addr, if_valid, if_pc, if_instr and if_misalign. FIFO is empty and the FSM is in IDLE. Reset mid-transaction drops the outstanding request, and any later mem_rvalid is ignored until a new request is issued.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its pc is held in a register.
  - DROP: request outstanding but flushed; its response is discarded.
- Credit rule: space = DEPTH - count - (state!=IDLE). pc_ready = (state==IDLE) & (space>0) & !flush. This is combinational.
- IDLE, on pc_valid&pc_ready:
  - Aligned pc: mem_req=1 for one cycle with mem_addr; latch pc; go to WAIT.
  - Misaligned pc: no memory access; push {pc, NOP, misalign=1} into the FIFO the same edge; stay IDLE.
- WAIT:
  - On mem_rvalid: push {held pc, mem_rdata, 0}; go to IDLE. The earliest response is 1 cycle after mem_req, so minimum pc-to-if_valid latency is 2 cycles.
  - On flush: go to DROP.
  - flush and mem_rvalid in the same cycle: the response is discarded; go to IDLE.
- DROP: on mem_rvalid, discard the data and go to IDLE. flush has no further effect.
- mem_rvalid in IDLE is ignored. This is a protocol error; simulation asserts.
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH, count 0..DEPTH.
  - Pop on if_valid&if_ready.
  - Simultaneous push and pop when full is allowed (count unchanged). The credit rule guarantees a push never overflows.
  - Head outputs are registered from the storage array. if_valid = (count!=0).
  - Holds the head stable while if_valid&!if_ready.
- flush:
  - Synchronous. At the next edge count=0 and pointers=0, and any pop or push in that cycle is cancelled.
  - pc_ready=0 during flush; the new target is accepted from the next cycle.

Decomposition:
- Shared package (the processor package): NOP constant 32'h00000013, fetch-state enum {IDLE, WAIT, DROP}, AW/DW defaults.
- One natural sub-module: fetch_fifo, a DEPTH-entry sync FIFO with flush, push/pop and count.
- FSM and credit logic stay in the top level.

Test Plan:
- Single fetch:
  - Stimulus: reset, then pc=8'h04 valid, memory returns 32'h00500093 one cycle after mem_req.
  - Response: mem_addr=8'h04, and if_valid on the 2nd cycle after acceptance with if_pc=04, if_instr=00500093, if_misalign=0.
- Backpressure:
  - Stimulus: if_ready=0; fetch pc 00, 04, 08.
  - Response: two entries buffered; pc_ready stays 0 after the 2nd response, and 08 is not requested until one pop; entries pop in order 00, 04.
- Variable latency:
  - Stimulus: mem_rvalid 5 cycles after the request.
  - Response: pc_ready=0 and mem_req does not re-pulse during the wait; the instruction is delivered once.
- Flush in flight:
  - Stimulus: request pc=10, then flush before mem_rvalid, then pc=40 valid.
  - Response: the response for 10 is dropped and 40 is requested only after it returns; the only output is if_pc=40.
- Misaligned:
  - Stimulus: pc=8'h06.
  - Response: no mem_req; next cycle if_valid=1, if_pc=06, if_instr=00000013, if_misalign=1.
- Async reset mid-WAIT:
  - Stimulus: rst low while outstanding.
  - Response: all outputs 0 immediately; the late mem_rvalid after release produces no if_valid.
